// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - op codes, FSM states and sizing helper for serial_alu
package serial_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// rtl/serial_alu_slice.sv - combinational 1-bit ALU slice
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carryin,
    input  logic [2:0] control,
    output logic       out,
    output logic       carryout
);

    logic b_eff;

    always_comb begin
        out      = 1'b0;
        carryout = 1'b0;
        b_eff    = b ^ (control == ALU_SUB);
        case (control)
            ALU_ADD, ALU_SUB: begin
                out      = a ^ b_eff ^ carryin;
                carryout = (a & b_eff) | (a & carryin) | (b_eff & carryin);
            end
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_NOR: out = ~(a | b);
            ALU_XOR: out = a ^ b;
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU, LSB first; SERIAL_ALU_CARRYOUT_EN adds carryout port
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
`ifdef SERIAL_ALU_CARRYOUT_EN
    ,
    output logic             carryout
`endif
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_out;
    logic             bit_cout;
    logic             arith;
    logic [WIDTH-1:0] result;

    serial_alu_slice u_slice (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .carryin  (carry),
        .control  (op),
        .out      (bit_out),
        .carryout (bit_cout)
    );

    assign arith  = (op == ALU_ADD) || (op == ALU_SUB);
    // Value acc will hold after this edge; on the last bit it is the full result.
    assign result = {bit_out, acc[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            op       <= 3'd0;
`ifdef SERIAL_ALU_CARRYOUT_EN
            carryout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        op    <= control;
                        carry <= (control == ALU_SUB);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= result;
                    carry <= bit_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        out      <= result;
                        overflow <= arith & (carry ^ bit_cout);
                        zero     <= ~|result;
                        negative <= result[WIDTH-1];
`ifdef SERIAL_ALU_CARRYOUT_EN
                        carryout <= arith & bit_cout;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - randomized self-checking bench for serial_alu at WIDTH 32 and 8
module tb_serial_alu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  control = 3'd0;

    logic        busy32, done32, ovf32, zero32, neg32;
    logic [31:0] out32;
    logic        busy8, done8, ovf8, zero8, neg8;
    logic [7:0]  out8;
`ifdef SERIAL_ALU_CARRYOUT_EN
    logic        co32, co8;
`endif

    logic        sel8 = 1'b0;
    logic        o_busy, o_done, o_ovf, o_zero, o_neg, o_co;
    logic [31:0] o_out;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    serial_alu #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start), .A(A), .B(B), .control(control),
        .busy(busy32), .done(done32), .out(out32), .overflow(ovf32), .zero(zero32),
        .negative(neg32)
`ifdef SERIAL_ALU_CARRYOUT_EN
        , .carryout(co32)
`endif
    );

    serial_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start), .A(A[7:0]), .B(B[7:0]), .control(control),
        .busy(busy8), .done(done8), .out(out8), .overflow(ovf8), .zero(zero8),
        .negative(neg8)
`ifdef SERIAL_ALU_CARRYOUT_EN
        , .carryout(co8)
`endif
    );

    always_comb begin
        o_co = 1'b0;
        if (sel8) begin
            o_busy = busy8; o_done = done8; o_out = {24'd0, out8};
            o_ovf = ovf8; o_zero = zero8; o_neg = neg8;
`ifdef SERIAL_ALU_CARRYOUT_EN
            o_co = co8;
`endif
        end else begin
            o_busy = busy32; o_done = done32; o_out = out32;
            o_ovf = ovf32; o_zero = zero32; o_neg = neg32;
`ifdef SERIAL_ALU_CARRYOUT_EN
            o_co = co32;
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on w-bit values; returns {carryout, overflow, result}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        longint m, ua, ub, sa, sb, r;
        bit ovf, co;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua > (m >> 1)) ? ua - (m + 1) : ua;
        sb = (ub > (m >> 1)) ? ub - (m + 1) : ub;
        ovf = 1'b0;
        co  = 1'b0;
        case (c)
            3'd2: begin r = sa + sb; co = (ua + ub) > m; end
            3'd3: begin r = sa - sb; co = (ua >= ub); end
            3'd4: r = ua & ub;
            3'd5: r = ua | ub;
            3'd6: r = ~(ua | ub);
            3'd7: r = ua ^ ub;
            default: r = 0;
        endcase
        if (c == 3'd2 || c == 3'd3)
            ovf = (r > (m >> 1)) || (r < -((m >> 1) + 1));
        r = r & m;
        return {co, ovf, r[31:0]};
    endfunction

    // Starts at a negedge, returns at the negedge where done is high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input bit noise, output int acc_cyc, output logic [31:0] res);
        logic [33:0] exp;
        logic [31:0] prev;
        int w, idx, bad_busy, bad_out;
        bit seen;
        w = sel8 ? 8 : 32;
        exp = model(w, a, b, c);
        res = exp[31:0];
        prev = o_out;
        A = a; B = b; control = c; start = 1'b1;
        @(negedge clock);
        acc_cyc = cyc;
        start = 1'b0;
        idx = 1; bad_busy = 0; bad_out = 0; seen = 0;
        while (idx <= w + 5 && !seen) begin
            if (o_done) begin
                seen = 1;
            end else begin
                if (!o_busy) bad_busy++;
                if (o_out !== prev) bad_out++;
                if (noise) begin
                    A = $urandom; B = $urandom; control = 3'($urandom); start = 1'($urandom);
                end
                @(negedge clock);
                idx++;
            end
        end
        start = 1'b0;
        check("latency", idx, w + 1);
        check("busy_run", bad_busy, 0);
        check("out_hold", bad_out, 0);
        check("busy_fin", o_busy, 0);
        check("out", o_out, exp[31:0]);
        check("overflow", o_ovf, exp[32]);
        check("zero", o_zero, exp[31:0] == 0);
        check("negative", o_neg, exp[w-1]);
`ifdef SERIAL_ALU_CARRYOUT_EN
        check("carryout", o_co, exp[33]);
`endif
    endtask

    task automatic after_done(input logic [31:0] res);
        @(negedge clock);
        check("done_pulse", o_done, 0);
        check("idle_busy", o_busy, 0);
        check("out_held", o_out, res);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_out", {o_busy, o_done, o_ovf, o_zero, o_neg, o_co, o_out}, 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("idle_hold", {o_busy, o_done, o_ovf, o_zero, o_neg, o_co, o_out}, 0);
        end
    endtask

    task automatic mid_reset(input int w);
        int dones;
        A = $urandom; B = $urandom; control = 3'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_out", {o_busy, o_done, o_ovf, o_zero, o_neg, o_co, o_out}, 0);
        reset = 1'b0;
        dones = 0;
        repeat (w + 4) begin
            @(negedge clock);
            if (o_done || o_busy) dones++;
        end
        check("midrst_quiet", dones, 0);
    endtask

    task automatic random_ops(input int n);
        int ac;
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            do_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), ac, r);
            if ($urandom_range(0, 1) == 0) after_done(r);
        end
    endtask

    initial begin
        int a1, a2;
        logic [31:0] r;
        @(negedge clock);
        sel8 = 1'b0;
        do_reset();

        do_op(32'h7FFFFFFF, 32'h1, 3'd2, 0, a1, r);
        after_done(r);
        do_op(32'h12345678, 32'h12345678, 3'd3, 0, a1, r);
        after_done(r);
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 0, a1, r);
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd7, 0, a2, r);
        check("b2b_gap", a2 - a1, 33);
        after_done(r);
        do_op(32'h89ABCDEF, 32'h01234567, 3'd6, 1, a1, r);
        after_done(r);
        mid_reset(32);
        do_op($urandom, $urandom, 3'd1, 0, a1, r);
        after_done(r);
        random_ops(25);

        sel8 = 1'b1;
        do_reset();
        do_op(32'h80, 32'h01, 3'd3, 0, a1, r);
        after_done(r);
        do_op(32'h7F, 32'h01, 3'd2, 1, a1, r);
        do_op(32'hF0, 32'h0F, 3'd0, 0, a2, r);
        check("b2b_gap8", a2 - a1, 9);
        after_done(r);
        mid_reset(8);
        random_ops(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
